// File: rtl/vmem_pkg.sv
// Shared types and defaults for the vector memory stream controller.
package vmem_pkg;

  localparam int unsigned DEF_WIDTH = 24;
  localparam int unsigned DEF_DEPTH = 10000;
  localparam int unsigned DEF_LANES = 8;
  localparam int unsigned DEF_SW    = 8;

  typedef enum logic [2:0] {
    IDLE,
    STORE,
    LOAD,
    RESP,
    DUMP,
    DONE_IO
  } state_t;

  // Bit offset of a lane inside a packed LANES*WIDTH vector.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/vmem_ram.sv
// Single-port synchronous RAM, one-cycle registered read, read data held when re is low.
module vmem_ram
  import vmem_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/vmem_stream_ctrl.sv
// Vector load/store controller with programmable stride plus a backpressured
// memory dump stream, sharing one single-port RAM.
module vmem_stream_ctrl
  import vmem_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned LANES = DEF_LANES,
  parameter int unsigned SW    = DEF_SW,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [AW-1:0]          req_addr,
  input  logic [SW-1:0]          req_stride,
  input  logic [LANES*WIDTH-1:0] req_wdata,
  output logic                   resp_valid,
  output logic [LANES*WIDTH-1:0] resp_rdata,
  output logic                   resp_error,
  input  logic                   io_start,
  input  logic [AW-1:0]          io_base,
  input  logic [AW:0]            io_len,
  output logic                   io_valid,
  input  logic                   io_ready,
  output logic [WIDTH-1:0]       io_data,
  output logic                   io_busy,
  output logic                   io_done
);

  localparam int unsigned EW = AW + SW + 4;
  localparam int unsigned CW = $clog2(LANES + 1);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned VW = LANES * WIDTH;

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [EW-1:0]    addr_q;
  logic [SW-1:0]    stride_q;
  logic [VW-1:0]    wdata_q;
  logic [VW-1:0]    acc_q;
  logic             err_q;
  logic             we_q;
  logic             ld_oob_q;
  logic [LW-1:0]    rem_q;
  logic             pend_q;
  logic             pend_oob_q;

  logic             oob;
  logic             issue;
  logic             out_load;
  logic             ram_we;
  logic             ram_re;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_wdata;
  logic [WIDTH-1:0] ram_rdata;

  assign oob = (addr_q >= EW'(DEPTH));

  vmem_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next state and RAM port control; pend_q marks an unconsumed word on ram_rdata.
  always_comb begin
    state_n   = state;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    issue     = 1'b0;
    out_load  = 1'b0;
    ram_addr  = AW'(addr_q);
    ram_wdata = wdata_q[lane_lsb(32'(cnt), WIDTH) +: WIDTH];
    case (state)
      IDLE: begin
        if (req_valid)     state_n = req_we ? STORE : LOAD;
        else if (io_start) state_n = (io_len == '0) ? DONE_IO : DUMP;
      end
      STORE: begin
        ram_we = !oob;
        if (32'(cnt) == LANES - 1) state_n = RESP;
      end
      LOAD: begin
        ram_re = (32'(cnt) < LANES) && !oob;
        if (32'(cnt) == LANES) state_n = RESP;
      end
      RESP: state_n = IDLE;
      DUMP: begin
        out_load = pend_q && (!io_valid || io_ready);
        issue    = (rem_q != '0) && (!pend_q || out_load);
        ram_re   = issue && !oob;
        if ((rem_q == '0) && !pend_q && io_valid && io_ready) state_n = DONE_IO;
      end
      DONE_IO: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
      io_valid   <= 1'b0;
      io_data    <= '0;
      io_busy    <= 1'b0;
      io_done    <= 1'b0;
      cnt        <= '0;
      addr_q     <= '0;
      stride_q   <= '0;
      wdata_q    <= '0;
      acc_q      <= '0;
      err_q      <= 1'b0;
      we_q       <= 1'b0;
      ld_oob_q   <= 1'b0;
      rem_q      <= '0;
      pend_q     <= 1'b0;
      pend_oob_q <= 1'b0;
    end else begin
      req_ready  <= (state_n == IDLE);
      resp_valid <= (state == RESP);
      io_busy    <= (state_n == DUMP);
      io_done    <= (state_n == DONE_IO);
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req_valid) begin
            addr_q   <= EW'(req_addr);
            stride_q <= req_stride;
            wdata_q  <= req_wdata;
            we_q     <= req_we;
            acc_q    <= '0;
            err_q    <= 1'b0;
          end else if (io_start) begin
            addr_q     <= EW'(io_base);
            rem_q      <= io_len;
            pend_q     <= 1'b0;
            pend_oob_q <= 1'b0;
          end
        end
        STORE: begin
          cnt    <= cnt + CW'(1);
          addr_q <= addr_q + EW'(stride_q);
          if (oob) err_q <= 1'b1;
        end
        LOAD: begin
          cnt <= cnt + CW'(1);
          if (32'(cnt) < LANES) begin
            addr_q   <= addr_q + EW'(stride_q);
            ld_oob_q <= oob;
            if (oob) err_q <= 1'b1;
          end
          // Capture lane cnt-1, whose read was issued on the previous edge.
          if (cnt != '0)
            acc_q[lane_lsb(32'(cnt) - 32'd1, WIDTH) +: WIDTH] <= ld_oob_q ? '0 : ram_rdata;
        end
        RESP: begin
          resp_error <= err_q;
          if (!we_q) resp_rdata <= acc_q;
        end
        DUMP: begin
          if (issue) begin
            addr_q     <= addr_q + EW'(1);
            rem_q      <= rem_q - LW'(1);
            pend_oob_q <= oob;
          end
          pend_q <= issue | (pend_q & ~out_load);
          if (out_load) begin
            io_valid <= 1'b1;
            io_data  <= pend_oob_q ? '0 : ram_rdata;
          end else if (io_ready) begin
            io_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vmem_stream_ctrl.sv
// Scoreboard bench for vmem_stream_ctrl: vector load/store, stride, range errors, dump stream.
module tb_vmem_stream_ctrl;

  localparam int unsigned WIDTH = 24;
  localparam int unsigned DEPTH = 10000;
  localparam int unsigned LANES = 8;
  localparam int unsigned SW    = 8;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned VW    = LANES * WIDTH;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_we = 1'b0;
  logic [AW-1:0]    req_addr = '0;
  logic [SW-1:0]    req_stride = '0;
  logic [VW-1:0]    req_wdata = '0;
  logic             resp_valid;
  logic [VW-1:0]    resp_rdata;
  logic             resp_error;
  logic             io_start = 1'b0;
  logic [AW-1:0]    io_base = '0;
  logic [AW:0]      io_len = '0;
  logic             io_valid;
  logic             io_ready = 1'b0;
  logic [WIDTH-1:0] io_data;
  logic             io_busy;
  logic             io_done;

  typedef struct {
    logic          err;
    logic          is_load;
    logic [VW-1:0] rdata;
  } resp_t;

  resp_t            resp_q[$];
  logic [WIDTH-1:0] io_q[$];
  logic [WIDTH-1:0] model [int];
  int checks = 0;
  int errors = 0;

  vmem_stream_ctrl #(
    .WIDTH (WIDTH), .DEPTH (DEPTH), .LANES (LANES), .SW (SW), .AW (AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_stride (req_stride),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error),
    .io_start   (io_start),
    .io_base    (io_base),
    .io_len     (io_len),
    .io_valid   (io_valid),
    .io_ready   (io_ready),
    .io_data    (io_data),
    .io_busy    (io_busy),
    .io_done    (io_done)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [VW-1:0] lanes_seq(input int first);
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*WIDTH +: WIDTH] = WIDTH'(first + i);
    return v;
  endfunction

  // Drive one request; on return the accept edge has just passed (sample point e=0).
  task automatic issue_req(input logic we, input int base, input int stride,
                           input logic [VW-1:0] data, input bit push);
    resp_t r;
    int    a;
    int    budget;
    budget = 0;
    while (!req_ready && budget < 100) begin @(posedge clk); #1; budget++; end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL req_ready_wait got %0b exp 1", req_ready);
    end
    req_we = we; req_addr = AW'(base); req_stride = SW'(stride); req_wdata = data;
    req_valid = 1'b1;
    r.err = 1'b0; r.is_load = !we; r.rdata = '0;
    for (int i = 0; i < LANES; i++) begin
      a = base + i * stride;
      if (a >= int'(DEPTH)) r.err = 1'b1;
      else if (we && push) model[a] = data[i*WIDTH +: WIDTH];
      else if (!we) r.rdata[i*WIDTH +: WIDTH] = model.exists(a) ? model[a] : '0;
    end
    if (push) resp_q.push_back(r);
    @(posedge clk); #1;
    req_valid = 1'b0; req_wdata = ~data; req_addr = AW'(base + 5); req_stride = SW'(stride + 1);
  endtask

  task automatic wait_resp(input int exp_edges);
    int    e;
    resp_t r;
    e = 0;
    while (!resp_valid && e < 40) begin @(posedge clk); #1; e++; end
    checks++;
    if (e != exp_edges) begin
      errors++; $display("FAIL resp_latency got %0d exp %0d", e, exp_edges);
    end
    checks++;
    if (resp_q.size() == 0) begin
      errors++; $display("FAIL resp_unexpected got entry exp none");
    end else begin
      r = resp_q.pop_front();
      checks++;
      if (resp_error !== r.err) begin
        errors++; $display("FAIL resp_error got %0b exp %0b", resp_error, r.err);
      end
      if (r.is_load) begin
        checks++;
        if (resp_rdata !== r.rdata) begin
          errors++; $display("FAIL resp_rdata got %h exp %h", resp_rdata, r.rdata);
        end
      end
    end
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL resp_pulse got %0b exp 0", resp_valid);
    end
  endtask

  // io_start must already be driven; consumes the stream with optional 1,0,0,1 ready pattern.
  task automatic dump_stream(input int base, input int len, input bit stall);
    int               e, budget, vcount, dcount, a;
    bit               pv, pr, first;
    logic [WIDTH-1:0] pd, exp_w;
    logic [3:0]       pat;
    pat = 4'b1001;
    for (int k = 0; k < len; k++) begin
      a = base + k;
      io_q.push_back((a < int'(DEPTH) && model.exists(a)) ? model[a] : '0);
    end
    budget = 0;
    while (!io_busy && !io_done && budget < 100) begin @(posedge clk); #1; budget++; end
    checks++;
    if (!(io_busy || io_done)) begin
      errors++; $display("FAIL io_start_wait got busy=%0b exp 1", io_busy);
    end
    io_start = 1'b0;
    e = 0; pv = 0; pr = 0; pd = '0; first = 0; vcount = 0; dcount = 0;
    while (e < 300) begin
      if (pv && pr) begin
        checks++;
        if (io_q.size() == 0) begin
          errors++; $display("FAIL io_extra_word got %h exp none", pd);
        end else begin
          exp_w = io_q.pop_front();
          if (pd !== exp_w) begin
            errors++; $display("FAIL io_data got %h exp %h", pd, exp_w);
          end
        end
      end else if (pv) begin
        checks++;
        if (io_valid !== 1'b1 || io_data !== pd) begin
          errors++; $display("FAIL io_hold got %0b/%h exp 1/%h", io_valid, io_data, pd);
        end
      end
      if (io_valid) vcount++;
      if (io_valid && !first) begin
        first = 1;
        checks++;
        if (e != 2) begin
          errors++; $display("FAIL io_first_latency got %0d exp 2", e);
        end
      end
      if (io_done) begin dcount++; break; end
      io_ready = stall ? pat[e % 4] : 1'b1;
      pv = io_valid; pd = io_data; pr = io_ready;
      @(posedge clk); #1; e++;
    end
    checks++;
    if (io_q.size() != 0) begin
      errors++; $display("FAIL io_words_missing got %0d left exp 0", io_q.size());
      io_q.delete();
    end
    checks++;
    if (io_busy !== 1'b0) begin
      errors++; $display("FAIL io_busy_after_done got %0b exp 0", io_busy);
    end
    repeat (4) begin
      @(posedge clk); #1;
      if (io_done) dcount++;
      if (io_valid) vcount++;
    end
    checks++;
    if (dcount != 1) begin
      errors++; $display("FAIL io_done_pulses got %0d exp 1", dcount);
    end
    if (len == 0) begin
      checks++;
      if (vcount != 0) begin
        errors++; $display("FAIL io_valid_empty got %0d exp 0", vcount);
      end
    end
    io_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_error, io_valid, io_busy, io_done} !== 6'b100000) begin
      errors++; $display("FAIL reset_flags got %b exp 100000",
        {req_ready, resp_valid, resp_error, io_valid, io_busy, io_done});
    end
    checks++;
    if (resp_rdata !== '0 || io_data !== '0) begin
      errors++; $display("FAIL reset_data got %h/%h exp 0/0", resp_rdata, io_data);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_reset got %0b exp 1", req_ready);
    end
  endtask

  task automatic test_store_load();
    issue_req(1'b1, 'h18, 1, lanes_seq(1), 1'b1);
    wait_resp(LANES + 1);
    issue_req(1'b0, 'h18, 1, '0, 1'b1);
    wait_resp(LANES + 2);
  endtask

  task automatic test_stride();
    issue_req(1'b1, 'h21, 0, lanes_seq('hA00000), 1'b1);
    wait_resp(LANES + 1);
    issue_req(1'b1, 'h20, 3, lanes_seq(9), 1'b1);
    wait_resp(LANES + 1);
    issue_req(1'b0, 'h20, 3, '0, 1'b1);
    wait_resp(LANES + 2);
    issue_req(1'b0, 'h21, 0, '0, 1'b1);
    wait_resp(LANES + 2);
  endtask

  task automatic test_out_of_range();
    issue_req(1'b1, 9998, 1, lanes_seq('hB00000), 1'b1);
    wait_resp(LANES + 1);
    issue_req(1'b0, 9998, 1, '0, 1'b1);
    wait_resp(LANES + 2);
  endtask

  task automatic test_dump();
    io_base = AW'('h18); io_len = (AW+1)'(8); io_start = 1'b1;
    dump_stream('h18, 8, 1'b1);
    io_base = AW'('h18); io_len = '0; io_start = 1'b1;
    dump_stream('h18, 0, 1'b0);
    io_base = AW'(9998); io_len = (AW+1)'(4); io_start = 1'b1;
    dump_stream(9998, 4, 1'b1);
  endtask

  task automatic test_back_to_back();
    io_base = AW'('h40); io_len = (AW+1)'(8); io_start = 1'b1;
    issue_req(1'b1, 'h40, 1, lanes_seq('hC00000), 1'b1);
    wait_resp(LANES + 1);
    dump_stream('h40, 8, 1'b0);
  endtask

  task automatic test_load_ignores_io();
    issue_req(1'b0, 'h18, 1, '0, 1'b1);
    io_base = AW'('h18); io_len = (AW+1)'(3); io_start = 1'b1;
    wait_resp(LANES + 2);
    dump_stream('h18, 3, 1'b1);
  endtask

  task automatic test_reset_mid_store();
    int seen;
    issue_req(1'b1, 'h60, 1, lanes_seq('hEEEE00), 1'b1);
    wait_resp(LANES + 1);
    issue_req(1'b1, 'h60, 1, lanes_seq('hD00000), 1'b0);
    for (int i = 0; i < 3; i++) model['h60 + i] = WIDTH'('hD00000 + i);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_error, io_valid, io_busy, io_done} !== 6'b100000) begin
      errors++; $display("FAIL midreset_flags got %b exp 100000",
        {req_ready, resp_valid, resp_error, io_valid, io_busy, io_done});
    end
    checks++;
    if (resp_rdata !== '0 || io_data !== '0) begin
      errors++; $display("FAIL midreset_data got %h/%h exp 0/0", resp_rdata, io_data);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (12) begin @(posedge clk); #1; if (resp_valid) seen++; end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL midreset_resp got %0d exp 0", seen);
    end
    issue_req(1'b0, 'h60, 1, '0, 1'b1);
    wait_resp(LANES + 2);
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_stride();
    test_out_of_range();
    test_dump();
    test_back_to_back();
    test_load_ignores_io();
    test_reset_mid_store();
    checks++;
    if (resp_q.size() != 0) begin
      errors++; $display("FAIL resp_leftover got %0d exp 0", resp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
